// File: rtl/cmsdk_rst_pkg.sv
// Shared types and constants for the CMSDK reset controller: FSM state encoding
// and the bit positions of the sticky reset-cause register.
package cmsdk_rst_pkg;

  typedef enum logic [1:0] {
    POR_SYNC = 2'd0,
    POR_WAIT = 2'd1,
    RUN      = 2'd2,
    SYS_HOLD = 2'd3
  } rst_state_e;

  localparam int CAUSE_W      = 3;
  localparam int CAUSE_SYSREQ = 0;
  localparam int CAUSE_LOCKUP = 1;
  localparam int CAUSE_WDOG   = 2;

endpackage

// File: rtl/cmsdk_rst_ctrl_if.sv
// Soft reset request inputs and reset tree outputs of the reset controller.
// The controller takes the slave side; the CPU/board/bench takes the master side.
interface cmsdk_rst_ctrl_if;
  import cmsdk_rst_pkg::*;

  logic               SYSRESETREQ;
  logic               LOCKUP;
  logic               LOCKUPRESET;
  logic               WDOGRESREQ;
  logic               RSTCAUSE_CLR;
  logic               PORESETn;
  logic               HRESETn;
  logic [CAUSE_W-1:0] RSTCAUSE;
  logic [1:0]         RSTSTATE;

  modport master (
    output SYSRESETREQ, LOCKUP, LOCKUPRESET, WDOGRESREQ, RSTCAUSE_CLR,
    input  PORESETn, HRESETn, RSTCAUSE, RSTSTATE
  );

  modport slave (
    input  SYSRESETREQ, LOCKUP, LOCKUPRESET, WDOGRESREQ, RSTCAUSE_CLR,
    output PORESETn, HRESETn, RSTCAUSE, RSTSTATE
  );

endinterface

// File: rtl/cmsdk_rst_sync.sv
// Asynchronous-assert, synchronous-release reset synchronizer. rel_next is the
// value the output will take on the next edge, so the FSM can track it in step.
module cmsdk_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n,
  output logic rel_next
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = chain[STAGES-1];
  assign rel_next   = chain[STAGES-2];

endmodule

// File: rtl/cmsdk_rst_ctrl.sv
// Reset sequencer: synchronized POR release, staggered HRESETn release, bounded
// soft-reset pulses from CPU/watchdog requests, and a sticky reset-cause record.
module cmsdk_rst_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int POR_DELAY   = 8,
  parameter int SYS_HOLD    = 4
) (
  input  logic              CLK,
  input  logic              NRST,
  cmsdk_rst_ctrl_if.slave   bus
);
  import cmsdk_rst_pkg::*;

  localparam int CNT_MAX = (POR_DELAY > SYS_HOLD) ? POR_DELAY : SYS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SYS_HOLD - 1);

  rst_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic               hresetn;
  logic [CAUSE_W-1:0] cause;
  logic [CAUSE_W-1:0] cause_src;
  logic               poresetn;
  logic               por_rel_next;
  logic               req;
  logic               soft_active;

  cmsdk_rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_por_sync (
    .clk        (CLK),
    .rst_n      (NRST),
    .rst_sync_n (poresetn),
    .rel_next   (por_rel_next)
  );

  assign req = bus.SYSRESETREQ | (bus.LOCKUP & bus.LOCKUPRESET) | bus.WDOGRESREQ;

  // The state enum literal SYS_HOLD is shadowed by the parameter, so scope it.
  assign soft_active = (state == RUN) || (state == cmsdk_rst_pkg::SYS_HOLD);

  always_comb begin
    cause_src               = '0;
    cause_src[CAUSE_SYSREQ] = bus.SYSRESETREQ;
    cause_src[CAUSE_LOCKUP] = bus.LOCKUP & bus.LOCKUPRESET;
    cause_src[CAUSE_WDOG]   = bus.WDOGRESREQ;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state   <= POR_SYNC;
      cnt     <= '0;
      hresetn <= 1'b0;
      cause   <= '0;
    end else begin
      // A set on the same edge as a clear wins for that bit.
      cause <= (bus.RSTCAUSE_CLR ? '0 : cause) | (soft_active ? cause_src : '0);

      case (state)
        POR_SYNC: begin
          if (por_rel_next) begin
            state <= POR_WAIT;
            cnt   <= '0;
          end
        end
        POR_WAIT: begin
          if (cnt == POR_LAST) begin
            state   <= RUN;
            hresetn <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (req) begin
            state   <= cmsdk_rst_pkg::SYS_HOLD;
            hresetn <= 1'b0;
            cnt     <= '0;
          end
        end
        cmsdk_rst_pkg::SYS_HOLD: begin
          if (cnt == HOLD_LAST) begin
            if (!req) begin
              state   <= RUN;
              hresetn <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= POR_SYNC;
      endcase
    end
  end

  assign bus.PORESETn = poresetn;
  assign bus.HRESETn  = hresetn;
  assign bus.RSTCAUSE = cause;
  assign bus.RSTSTATE = state;

endmodule

// File: tb/tb_cmsdk_rst_ctrl.sv
// Directed bench for cmsdk_rst_ctrl with default parameters (2 / 8 / 4).
module tb_cmsdk_rst_ctrl;

  logic clk;
  logic nrst;
  int   n_tests;
  int   n_fail;
  int   nlow;
  int   total;

  cmsdk_rst_ctrl_if bus ();

  cmsdk_rst_ctrl #(
    .SYNC_STAGES(2),
    .POR_DELAY  (8),
    .SYS_HOLD   (4)
  ) dut (
    .CLK (clk),
    .NRST(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until HRESETn is high; returns the number of further edges it stayed low.
  task automatic count_low(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.HRESETn === 1'b1) break;
      n++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nrst    = 1'b0;
    bus.SYSRESETREQ  = 1'b0;
    bus.LOCKUP       = 1'b0;
    bus.LOCKUPRESET  = 1'b0;
    bus.WDOGRESREQ   = 1'b0;
    bus.RSTCAUSE_CLR = 1'b0;

    // Reset state
    #2;
    chk("rst_poresetn", 32'(bus.PORESETn), 32'd0);
    chk("rst_hresetn",  32'(bus.HRESETn),  32'd0);
    chk("rst_cause",    32'(bus.RSTCAUSE), 32'd0);
    chk("rst_state",    32'(bus.RSTSTATE), 32'd0);
    step();
    step();

    // POR release between edges
    nrst = 1'b1;
    step();
    chk("por_edge1_poresetn", 32'(bus.PORESETn), 32'd0);
    step();
    chk("por_edge2_poresetn", 32'(bus.PORESETn), 32'd1);
    chk("por_edge2_state",    32'(bus.RSTSTATE), 32'd1);
    chk("por_edge2_hresetn",  32'(bus.HRESETn),  32'd0);
    repeat (7) step();
    chk("por_edge9_hresetn",  32'(bus.HRESETn),  32'd0);
    step();
    chk("por_edge10_hresetn", 32'(bus.HRESETn),  32'd1);
    chk("por_edge10_state",   32'(bus.RSTSTATE), 32'd2);
    chk("por_edge10_cause",   32'(bus.RSTCAUSE), 32'd0);

    // One-cycle SYSRESETREQ
    bus.SYSRESETREQ = 1'b1;
    step();
    chk("sys_hresetn_low", 32'(bus.HRESETn),  32'd0);
    chk("sys_state_hold",  32'(bus.RSTSTATE), 32'd3);
    chk("sys_cause",       32'(bus.RSTCAUSE), 32'b001);
    bus.SYSRESETREQ = 1'b0;
    count_low(nlow);
    chk("sys_low_cycles", 32'(1 + nlow),     32'd4);
    chk("sys_poresetn",   32'(bus.PORESETn), 32'd1);
    chk("sys_state_run",  32'(bus.RSTSTATE), 32'd2);

    // Clear cause, then WDOGRESREQ held for 10 cycles
    bus.RSTCAUSE_CLR = 1'b1;
    step();
    bus.RSTCAUSE_CLR = 1'b0;
    chk("clr_cause", 32'(bus.RSTCAUSE), 32'd0);
    bus.WDOGRESREQ = 1'b1;
    total = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.HRESETn === 1'b0) total++;
    end
    bus.WDOGRESREQ = 1'b0;
    count_low(nlow);
    chk("wdog_low_cycles", 32'(total + nlow),  32'd10);
    chk("wdog_cause",      32'(bus.RSTCAUSE),  32'b100);
    chk("wdog_state_run",  32'(bus.RSTSTATE),  32'd2);

    // LOCKUP without and then with LOCKUPRESET
    bus.RSTCAUSE_CLR = 1'b1;
    step();
    bus.RSTCAUSE_CLR = 1'b0;
    bus.LOCKUP = 1'b1;
    repeat (5) step();
    chk("lock_dis_hresetn", 32'(bus.HRESETn),  32'd1);
    chk("lock_dis_cause",   32'(bus.RSTCAUSE), 32'd0);
    chk("lock_dis_state",   32'(bus.RSTSTATE), 32'd2);
    bus.LOCKUPRESET = 1'b1;
    step();
    chk("lock_en_hresetn", 32'(bus.HRESETn),  32'd0);
    chk("lock_en_cause",   32'(bus.RSTCAUSE), 32'b010);
    bus.LOCKUP = 1'b0;
    count_low(nlow);
    chk("lock_low_cycles", 32'(1 + nlow), 32'd4);

    // Build cause 110, then clear on the same edge as a new SYSRESETREQ
    bus.WDOGRESREQ = 1'b1;
    step();
    bus.WDOGRESREQ = 1'b0;
    chk("pre_clr_cause", 32'(bus.RSTCAUSE), 32'b110);
    count_low(nlow);
    chk("pre_clr_low_cycles", 32'(1 + nlow), 32'd4);
    bus.SYSRESETREQ  = 1'b1;
    bus.RSTCAUSE_CLR = 1'b1;
    step();
    bus.RSTCAUSE_CLR = 1'b0;
    chk("clr_set_cause", 32'(bus.RSTCAUSE), 32'b001);
    chk("clr_set_state", 32'(bus.RSTSTATE), 32'd3);

    // NRST during SYS_HOLD with requests held through the POR sequence
    step();
    chk("hold_state", 32'(bus.RSTSTATE), 32'd3);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_poresetn", 32'(bus.PORESETn), 32'd0);
    chk("async_hresetn",  32'(bus.HRESETn),  32'd0);
    chk("async_cause",    32'(bus.RSTCAUSE), 32'd0);
    chk("async_state",    32'(bus.RSTSTATE), 32'd0);
    bus.WDOGRESREQ = 1'b1;
    bus.LOCKUP     = 1'b1;
    step();
    nrst = 1'b1;
    step();
    chk("repor_edge1_poresetn", 32'(bus.PORESETn), 32'd0);
    step();
    chk("repor_edge2_poresetn", 32'(bus.PORESETn), 32'd1);
    chk("repor_edge2_cause",    32'(bus.RSTCAUSE), 32'd0);
    repeat (7) step();
    chk("repor_edge9_hresetn",  32'(bus.HRESETn),  32'd0);
    chk("repor_edge9_state",    32'(bus.RSTSTATE), 32'd1);
    step();
    chk("repor_edge10_hresetn", 32'(bus.HRESETn),  32'd1);
    chk("repor_edge10_state",   32'(bus.RSTSTATE), 32'd2);
    chk("repor_edge10_cause",   32'(bus.RSTCAUSE), 32'd0);
    bus.SYSRESETREQ = 1'b0;
    bus.WDOGRESREQ  = 1'b0;
    bus.LOCKUP      = 1'b0;
    step();
    chk("repor_run_cause",   32'(bus.RSTCAUSE), 32'd0);
    chk("repor_run_hresetn", 32'(bus.HRESETn),  32'd1);

    // Simultaneous requests set every matching bit
    bus.SYSRESETREQ = 1'b1;
    bus.WDOGRESREQ  = 1'b1;
    step();
    bus.SYSRESETREQ = 1'b0;
    bus.WDOGRESREQ  = 1'b0;
    chk("multi_cause", 32'(bus.RSTCAUSE), 32'b101);
    count_low(nlow);
    chk("multi_low_cycles", 32'(1 + nlow), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
